// File: rtl/fsm_driver_pkg.sv
// Shared definitions for the job driver and the downstream fsm it controls:
// the fsm's reported state values and the driver's own state encoding.
package fsm_driver_pkg;

  // Values of the downstream fsm's state bus.
  localparam logic [7:0] FSM_IDLE = 8'd0;
  localparam logic [7:0] FSM_BUSY = 8'd1;

  // Driver sequencing states.
  typedef enum logic [2:0] {
    DRV_IDLE,
    DRV_ISSUE,
    DRV_WAIT_BUSY,
    DRV_RUN,
    DRV_FINISH,
    DRV_WAIT_IDLE
  } drv_state_e;

endpackage

// File: rtl/fsm_driver_fifo.sv
// DEPTH x 8 synchronous job FIFO. Overflowing pushes and underflowing pops
// are ignored. The head entry is visible on rdata without a pop.
module fsm_driver_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; entries are only read after
    // being written, and the pointers/count define validity.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fsm_driver.sv
// Job driver: queues run-length jobs and sequences each one through a
// downstream fsm with a start/done handshake, timing out if the fsm never
// reports busy. All outputs are registered.
module fsm_driver
  import fsm_driver_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_len,
  output logic       req_ready,
  input  logic [7:0] state,
  output logic       start,
  output logic       done,
  output logic       job_done,
  output logic [2:0] pending,
  output logic       error
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Wait counter only needs to hold 0..WAIT_MAX-1.
  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  drv_state_e    drv_q, drv_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          job_done_q, job_done_d;
  logic          error_q, error_d;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  fsm_driver_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_valid),
    .wdata (req_len),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready depends only on the registered occupancy, never on req_valid.
  assign req_ready = !fifo_full;
  assign pending   = 3'(fifo_count);
  assign start     = start_q;
  assign done      = done_q;
  assign job_done  = job_done_q;
  assign error     = error_q;

  // Driver next-state, counters, and next values of the registered outputs.
  always_comb begin
    drv_d      = drv_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    error_d    = error_q;
    job_done_d = 1'b0;
    fifo_pop   = 1'b0;
    case (drv_q)
      DRV_IDLE: begin
        if (!fifo_empty && state == FSM_IDLE) begin
          drv_d    = DRV_ISSUE;
          len_d    = fifo_rdata;
          fifo_pop = 1'b1;
        end
      end
      DRV_ISSUE: begin
        drv_d  = DRV_WAIT_BUSY;
        wait_d = '0;
      end
      DRV_WAIT_BUSY: begin
        if (state == FSM_BUSY) begin
          drv_d = DRV_RUN;
          cnt_d = len_q;
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          // This is the WAIT_MAX-th cycle without busy: drop the job.
          drv_d   = DRV_IDLE;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      DRV_RUN: begin
        if (cnt_q == '0) drv_d = DRV_FINISH;
        else             cnt_d = cnt_q - 8'd1;
      end
      DRV_FINISH: drv_d = DRV_WAIT_IDLE;
      DRV_WAIT_IDLE: begin
        if (state == FSM_IDLE) begin
          drv_d      = DRV_IDLE;
          job_done_d = 1'b1;
        end
      end
      default: drv_d = DRV_IDLE;
    endcase
    // Pulses are decodes of the next state, so they line up with ISSUE/FINISH.
    start_d = (drv_d == DRV_ISSUE);
    done_d  = (drv_d == DRV_FINISH);
  end

  // Driver state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      drv_q      <= DRV_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      job_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      drv_q      <= drv_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      start_q    <= start_d;
      done_q     <= done_d;
      job_done_q <= job_done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_fsm_driver.sv
// Bench for fsm_driver: plays the downstream fsm and a job source, and
// predicts every output each cycle from a timestamp-based job model.
module tb_fsm_driver;
  import fsm_driver_pkg::*;

  localparam int DEPTH    = 4;
  localparam int WAIT_MAX = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_len;
  logic       req_ready;
  logic [7:0] state;
  logic       start, done, job_done, error;
  logic [2:0] pending;

  always #5 clock = ~clock;

  fsm_driver #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .state     (state),
    .start     (start),
    .done      (done),
    .job_done  (job_done),
    .pending   (pending),
    .error     (error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued lengths plus absolute cycle stamps of the job.
  int cyc;
  int q[$];
  bit m_active;
  bit m_err;
  int job_len;
  int t_issue, t_busy, t_done, jd_at, idle_from;

  // Stimulus knobs.
  int plan[$];
  int push_pct, stuck_pct, dly_max, len_max, rst_pct_mil;
  bit rst_req;

  // Downstream fsm behaviour: 0 idle/stuck, 1 heading busy, 2 busy, 3 heading idle.
  int         f_phase;
  int         f_cnt;
  logic [7:0] f_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear(input int c);
    q.delete();
    m_active  = 1'b0;
    m_err     = 1'b0;
    t_issue   = -1;
    t_busy    = -1;
    t_done    = -1;
    jd_at     = -1;
    idle_from = c;
  endtask

  // Advance the model across the edge that ends cycle c.
  task automatic model_update(input int c, input bit r, input bit v, input int l, input logic [7:0] st);
    bit ready;
    if (r) begin
      model_clear(c + 1);
      return;
    end
    ready = (q.size() != DEPTH);
    if (!m_active && c >= idle_from && q.size() != 0 && st == FSM_IDLE) begin
      m_active = 1'b1;
      job_len  = q.pop_front();
      t_issue  = c + 1;
      t_busy   = -1;
      t_done   = -1;
    end else if (m_active) begin
      if (t_busy < 0) begin
        if (c >= t_issue + 1) begin
          if (st == FSM_BUSY) begin
            t_busy = c;
            t_done = c + 2 + job_len;   // len+1 RUN cycles, then FINISH
          end else if (c - t_issue == WAIT_MAX) begin
            m_err     = 1'b1;
            m_active  = 1'b0;
            idle_from = c + 1;
          end
        end
      end else if (c > t_done) begin
        if (st == FSM_IDLE) begin
          jd_at     = c + 1;
          m_active  = 1'b0;
          idle_from = c + 1;
        end
      end
    end
    if (v && ready) q.push_back(l);
  endtask

  task automatic check_outputs();
    check("start",     start,     32'(t_issue == cyc));
    check("done",      done,      32'(t_done == cyc));
    check("job_done",  job_done,  32'(jd_at == cyc));
    check("error",     error,     32'(m_err));
    check("pending",   pending,   32'(q.size()));
    check("req_ready", req_ready, 32'(q.size() != DEPTH));
    check("start_and_done", start & done, 32'(0));
  endtask

  // Drive one cycle of stimulus, advance the model, then check the next cycle.
  task automatic step();
    bit r, v, exp_start, exp_done;
    int l;
    exp_start = (t_issue == cyc);
    exp_done  = (t_done == cyc);
    r = rst_req || ($urandom_range(999) < rst_pct_mil);
    rst_req = 1'b0;
    if (plan.size() != 0) begin
      v = 1'b1;
      l = plan[0];
      if (!r && q.size() != DEPTH) void'(plan.pop_front());
    end else begin
      v = ($urandom_range(99) < push_pct);
      l = $urandom_range(len_max);
    end
    case (f_phase)
      1: if (f_cnt == 0) begin f_state = FSM_BUSY; f_phase = 2; end else f_cnt--;
      3: if (f_cnt == 0) begin f_state = FSM_IDLE; f_phase = 0; end else f_cnt--;
      default: ;
    endcase
    reset     = r;
    req_valid = v;
    req_len   = l[7:0];
    state     = f_state;
    model_update(cyc, r, v, l, f_state);
    if (exp_start) begin
      if ($urandom_range(99) < stuck_pct) f_phase = 0;
      else begin f_phase = 1; f_cnt = $urandom_range(dly_max); end
    end
    if (exp_done) begin
      f_phase = 3;
      f_cnt   = $urandom_range(dly_max);
    end
    if (r) begin
      f_phase = 0;
      f_state = FSM_IDLE;
    end
    @(posedge clock);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_len   = 8'd0;
    state     = FSM_IDLE;
    f_phase   = 0;
    f_cnt     = 0;
    f_state   = FSM_IDLE;
    rst_req   = 1'b0;
    push_pct  = 0;
    stuck_pct = 0;
    dly_max   = 0;
    len_max   = 0;
    rst_pct_mil = 0;
    repeat (3) @(posedge clock);
    #1;
    cyc = 0;
    model_clear(0);
    check_outputs();

    // Single job, len 2, prompt fsm.
    plan = '{2};
    run(15);

    // Zero-length jobs back to back, then a longer one.
    plan = '{0, 0, 3};
    run(40);

    // Stuck fsm: every job times out while the queue fills past DEPTH.
    stuck_pct = 100;
    plan = '{10, 11, 12, 13, 14};
    run(100);

    // Long job in RUN while the queue fills up behind it; error stays sticky.
    stuck_pct = 0;
    dly_max   = 1;
    plan = '{20, 1, 2, 3, 4, 5};
    run(120);

    // Reset in the middle of RUN.
    dly_max = 0;
    plan = '{30, 7};
    run(8);
    rst_req = 1'b1;
    run(10);

    // Randomized traffic with occasional stuck fsm and rare resets.
    push_pct    = 40;
    stuck_pct   = 15;
    dly_max     = 4;
    len_max     = 6;
    rst_pct_mil = 3;
    run(2000);

    // Drain.
    push_pct    = 0;
    rst_pct_mil = 0;
    run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
